mig_rd_engine: RTL

Parametrised MIG read-burst engine for the DDR user interface.
- Accepts one read job (start address, beat count) per request handshake and issues app read commands at a fixed address stride.
- Buffers returned beats in an internal FWFT FIFO, so the consumer may apply backpressure.
- Limits outstanding commands to FIFO free space, so MIG return data can never be dropped.

---
 rtl/mig_rd_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mig_rd_engine.sv
// MIG read-burst engine: issues strided app read commands for one job
// and returns the beats through a FWFT FIFO with consumer backpressure.
// Ports:
//   ui_clk, rst_n                        clock, async active-low reset
//   rd_req/_ready/_addr, rd_length       job request handshake
//   rd_busy, rd_done, rd_overflow        job status
//   rd_data/_valid/_ready                FIFO head to consumer
//   app_rd_addr/_cmd/_en, app_rdy        MIG command channel
//   app_rd_data/_valid/_end              MIG return channel
module mig_rd_engine #(
   parameter int ADDR_W    = 28,
   parameter int DATA_W    = 128,
   parameter int LEN_W     = 16,
   parameter int ADDR_STEP = 8,
   parameter int FIFO_AW   = 5
) (
   input  logic              ui_clk,
   input  logic              rst_n,
   input  logic              rd_req,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_req_addr,
   input  logic [LEN_W-1:0]  rd_length,
   output logic              rd_busy,
   output logic              rd_done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              rd_data_ready,
   output logic              rd_overflow,
   output logic [ADDR_W-1:0] app_rd_addr,
   output logic [2:0]        app_rd_cmd,
   output logic              app_rd_en,
   input  logic              app_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              app_rd_data_end
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_W = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cmd_cnt_q, cmd_cnt_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [FIFO_AW:0]  outst_q, outst_d;
   logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q, fill_w;
   logic              ovf_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              cmd_acc_w, pop_w, push_w, full_w, empty_w;
   logic [LEN_W-1:0]  pop_inc_w;
   logic              unused_w;

   assign unused_w = app_rd_data_end;

   // FIFO status; pointers carry one extra bit to tell full from empty
   assign fill_w    = wr_ptr_q - rd_ptr_q;
   assign full_w    = (fill_w == DEPTH_W);
   assign empty_w   = (wr_ptr_q == rd_ptr_q);
   assign pop_w     = !empty_w && rd_data_ready;
   assign push_w    = app_rd_data_valid && (!full_w || pop_w);
   assign pop_inc_w = {{(LEN_W-1){1'b0}}, pop_w};

   assign rd_data       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign rd_data_valid = !empty_w;
   assign rd_overflow   = ovf_q;
   assign app_rd_addr   = addr_q;
   assign app_rd_cmd    = 3'b001;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      cmd_cnt_d    = cmd_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      rd_req_ready = 1'b0;
      rd_busy      = 1'b1;
      rd_done      = 1'b0;
      app_rd_en    = 1'b0;
      cmd_acc_w    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            rd_req_ready = 1'b1;
            rd_busy      = 1'b0;
            if (rd_req) begin
               addr_d     = rd_req_addr;
               len_d      = rd_length;
               cmd_cnt_d  = '0;
               beat_cnt_d = '0;
               state_d    = (rd_length == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            // never request more beats than the FIFO can absorb
            app_rd_en  = (cmd_cnt_q < len_q) && (outst_q < DEPTH_W);
            cmd_acc_w  = app_rd_en && app_rdy;
            beat_cnt_d = beat_cnt_q + pop_inc_w;
            if (cmd_acc_w) begin
               addr_d    = addr_q + ADDR_W'(ADDR_STEP);
               cmd_cnt_d = cmd_cnt_q + LEN_W'(1);
               if (cmd_cnt_q + LEN_W'(1) == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // look at the post-pop count so done follows the last pop
            beat_cnt_d = beat_cnt_q + pop_inc_w;
            if (beat_cnt_d == len_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            rd_done = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      outst_d = outst_q;
      unique case ({cmd_acc_w, pop_w && (outst_q != '0)})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cmd_cnt_q  <= '0;
         beat_cnt_q <= '0;
         outst_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cmd_cnt_q  <= cmd_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         outst_q    <= outst_d;
         if (push_w) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (app_rd_data_valid && full_w && !pop_w) begin
            ovf_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge ui_clk) begin
      if (push_w) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= app_rd_data;
      end
   end

endmodule
